rsa_result_buffer: RTL and testbench
====================================

# rsa_result_buffer

Parametrised capture buffer for RSA co-processor results. Each completed modular exponentiation (`eoc` pulse while `en`) is pushed into a DEPTH-entry FIFO. Results drain to the narrow chip output as OUT_W-bit chunks over a valid/ready handshake, so the core can start the next operation before the host has read the last result. It sits between the exponentiation core's result register and the host-side output mux.

## Interface
- `WIDTH`, 8: result width in bits; must be an integer multiple of OUT_W.
- `DEPTH`, 4: number of result entries; power of two, ≥2.
- `OUT_W`, 8: output chunk width in bits.
- `clk`  in  1  clock.
- `rstb`  in  1  reset, synchronous, active-low.
- `en`  in  1  block enable; gates capture only.
- `eoc`  in  1  end-of-computation strobe from the core, one cycle per result.
- `R_i`  in  WIDTH  result word, valid in the cycle `eoc`=1.
- `clear`  in  1  synchronous flush: empties the FIFO, resets the chunk index, clears `overflow`.
- `out_valid`  out  1  head chunk available.
- `out_ready`  in  1  host accepts the chunk.
- `out_data`  out  OUT_W  current chunk of the head entry.
- `out_last`  out  1  current chunk is the final chunk of the entry.
- `count`  out  $clog2(DEPTH+1)  stored entries.
- `full`  out  1  count==DEPTH.
- `empty`  out  1  count==0.
- `overflow`  out  1  sticky: a result was dropped.

## Operation
- NCHUNK = WIDTH/OUT_W. Storage: DEPTH×WIDTH array, write pointer `wp`, read pointer `rp`, and a chunk index `ci` in 0..NCHUNK-1. Pointers wrap modulo DEPTH.
- Push condition: `en & eoc`.
  - Accepted when `!full`, or when `full` and a pop occurs in the same cycle.
  - Otherwise the result is dropped: `overflow` is set and the stored data is unchanged.
- Readout:
  - `out_valid = !empty`.
  - `out_data = mem[rp][ci*OUT_W +: OUT_W]`, least-significant chunk first.
  - `out_last = (ci == NCHUNK-1)`.
- Transfer occurs when `out_valid & out_ready`:
  - Non-last chunk: `ci` increments.
  - Last chunk: pop. `ci` goes to 0 and `rp` increments.
- `out_data` and `out_last` are don't-care when `out_valid`=0. Bench must not check them then.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `en`=0 blocks capture only. Readout continues.
- Priority: `rstb` > `clear` > push/pop. While `clear`=1, push and pop are ignored.
- A mid-entry host stall (`out_ready` low) holds `ci` and `out_data` stable.

## Timing
- Reset (rstb=0 at a clk edge), and likewise `clear`:
  - `wp`=`rp`=`ci`=0, `count`=0.
  - `empty`=1, `full`=0, `overflow`=0.
  - `out_valid`=0, `out_last`=0 when NCHUNK>1.
  - Memory contents are not reset.
- Capture latency: a push at edge N gives `out_valid`=1 and chunk 0 on `out_data` from edge N onward (combinational read of the registered array), i.e. in the cycle after `eoc`.
- Throughput: one chunk per cycle while `out_ready`=1. A full entry drains in NCHUNK cycles.
- `count`, `full`, `empty` and `overflow` are registered and update on the edge of the causing event.
- `overflow` is set on the edge of the dropped push.

## Structure
- Shared package `rsa_pkg`: `RSA_OUT_W` default constant and a `clog2`-based count-width localparam helper.
- Elaboration-time assertions (not package items): WIDTH % OUT_W == 0 and DEPTH a power of two.
- Natural sub-module: `rsa_fifo_mem`, holding the DEPTH×WIDTH register array with write port and combinational read port.
- The top level holds pointers, count, `ci`, flags and the handshake.

## Test plan
1. Reset and basic capture: WIDTH=16, OUT_W=8; push 0xA55A with `out_ready`=1 → next cycles `out_data`=0x5A (`out_last`=0), then 0xA5 (`out_last`=1), then `empty`=1.
2. Fill and overflow: DEPTH=4, `out_ready`=0, push 0x0001..0x0005 → `full`=1 after the 4th push, `overflow`=1 after the 5th. Drain yields 0x0001..0x0004 in order.
3. Full with simultaneous pop: full FIFO, push 0x1234 on the cycle of a last-chunk transfer → accepted, `count` stays 4, `overflow`=0, 0x1234 is read last.
4. Stall mid-entry: after the first chunk, hold `out_ready`=0 for 5 cycles → `out_data` is stable on the second chunk and `ci` is unchanged. Release → `out_last`=1 transfer.
5. `clear` with concurrent push, and `en`=0: `clear`=1 together with `eoc`=1 → `empty`=1 and `overflow`=0 next cycle. With `en`=0, `eoc` pulses → `count` stays 0.
6. Wrap-around: 10 push/drain pairs with DEPTH=4 → data matches in order across pointer wrap. Then a synchronous reset mid-drain → all outputs at reset values next cycle.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants and helpers for the RSA co-processor result path.
package rsa_pkg;

    localparam int RSA_OUT_W = 8;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rsa_fifo_mem.sv
// DEPTH x WIDTH result storage: one synchronous write port, one combinational read port.
module rsa_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Result array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rsa_result_buffer.sv
// Captures RSA results into a small FIFO and drains them as OUT_W-bit chunks,
// least-significant chunk first, over a valid/ready handshake.
module rsa_result_buffer
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OUT_W = RSA_OUT_W,
    localparam int CW   = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             eoc,
    input  logic [WIDTH-1:0] R_i,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / OUT_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % OUT_W != 0) begin : g_bad_width
        $fatal(1, "rsa_result_buffer: WIDTH must be a multiple of OUT_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "rsa_result_buffer: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CIW-1:0]   ci_q, ci_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic             push_req_s, push_ok_s, xfer_s, pop_s, last_s, mem_we_s;
    logic [WIDTH-1:0] rd_word_s;

    assign last_s     = (ci_q == CIW'(NCHUNK - 1));
    assign xfer_s     = !empty_q & out_ready;
    assign pop_s      = xfer_s & last_s;
    assign push_req_s = en & eoc;
    // A full buffer still takes a result when the head leaves in the same cycle.
    assign push_ok_s  = push_req_s & (!full_q | pop_s);
    assign mem_we_s   = push_ok_s & !clear & rstb;

    // Next-state for pointers, chunk index, occupancy and flags.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        ci_d    = ci_q;
        count_d = count_q;
        full_d  = full_q;
        empty_d = empty_q;
        ovf_d   = ovf_q;
        if (clear) begin
            wp_d    = AW'(0);
            rp_d    = AW'(0);
            ci_d    = CIW'(0);
            count_d = CW'(0);
            full_d  = 1'b0;
            empty_d = 1'b1;
            ovf_d   = 1'b0;
        end else begin
            if (xfer_s && last_s) begin
                ci_d = CIW'(0);
                rp_d = rp_q + AW'(1);
            end else if (xfer_s) begin
                ci_d = ci_q + CIW'(1);
            end else begin
                ci_d = ci_q;
            end
            if (push_ok_s) begin
                wp_d = wp_q + AW'(1);
            end else begin
                wp_d = wp_q;
            end
            if (push_req_s && !push_ok_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            full_d  = (count_d == CW'(DEPTH));
            empty_d = (count_d == CW'(0));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wp_q    <= AW'(0);
            rp_q    <= AW'(0);
            ci_q    <= CIW'(0);
            count_q <= CW'(0);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            ci_q    <= ci_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    rsa_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wp_q),
        .wdata (R_i),
        .raddr (rp_q),
        .rdata (rd_word_s)
    );

    assign out_valid = !empty_q;
    assign out_last  = last_s;
    assign out_data  = rd_word_s[ci_q*OUT_W +: OUT_W];
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rsa_result_buffer.sv
// Directed and randomized bench for rsa_result_buffer against a queue-based reference model.
module tb_rsa_result_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int OUT_W = 8;
    localparam int NCH   = WIDTH / OUT_W;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rstb = 1'b0, en = 1'b0, eoc = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] R_i = 16'h0000;
    logic             out_valid, out_last, full, empty, overflow;
    logic [OUT_W-1:0] out_data;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [$];
    int               mci = 0;
    bit               movf = 1'b0;
    bit               chk_en = 1'b0;

    always #5 clk = ~clk;

    rsa_result_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .eoc       (eoc),
        .R_i       (R_i),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        int unsigned word;
        check_val("count", 32'(count), 32'(mq.size()));
        check_val("full", 32'(full), 32'(mq.size() == DEPTH));
        check_val("empty", 32'(empty), 32'(mq.size() == 0));
        check_val("overflow", 32'(overflow), 32'(movf));
        check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            word = 32'(mq[0]);
            check_val("out_data", 32'(out_data), (word >> (mci * OUT_W)) % 256);
            check_val("out_last", 32'(out_last), 32'(mci == NCH - 1));
        end
    endtask

    // Model advance for one clock edge with the inputs currently driven.
    task automatic model_step();
        int  sz;
        bit  pop, acc;
        if (!rstb) begin
            mq.delete(); mci = 0; movf = 1'b0; chk_en = 1'b1;
        end else if (clear) begin
            mq.delete(); mci = 0; movf = 1'b0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && out_ready && (mci == NCH - 1);
            acc = en && eoc && ((sz < DEPTH) || pop);
            if (en && eoc && !acc) movf = 1'b1;
            if ((sz > 0) && out_ready) begin
                if (mci == NCH - 1) begin
                    void'(mq.pop_front());
                    mci = 0;
                end else begin
                    mci++;
                end
            end
            if (acc) mq.push_back(R_i);
        end
    endtask

    task automatic cyc(input logic rb, input logic e, input logic eo, input logic [WIDTH-1:0] r,
                       input logic cl, input logic rdy);
        @(negedge clk);
        if (chk_en) compare_all();
        rstb = rb; en = e; eoc = eo; R_i = r; clear = cl; out_ready = rdy;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [OUT_W-1:0] held;

    initial begin
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        after_edge();
        check_val("reset_empty", 32'(empty), 32'd1);
        check_val("reset_valid", 32'(out_valid), 32'd0);
        check_val("reset_last", 32'(out_last), 32'd0);

        // Basic capture and two-chunk readout.
        cyc(1'b1, 1'b1, 1'b1, 16'hA55A, 1'b0, 1'b1);
        after_edge();
        check_val("t1_chunk0", 32'(out_data), 32'h5A);
        check_val("t1_last0", 32'(out_last), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        after_edge();
        check_val("t1_chunk1", 32'(out_data), 32'hA5);
        check_val("t1_last1", 32'(out_last), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        after_edge();
        check_val("t1_empty", 32'(empty), 32'd1);

        // Fill and overflow, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
            after_edge();
            if (i == 4) check_val("t2_full", 32'(full), 32'd1);
            if (i == 4) check_val("t2_no_ovf", 32'(overflow), 32'd0);
            if (i == 5) check_val("t2_ovf", 32'(overflow), 32'd1);
        end
        for (int i = 0; i < 2 * DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Full buffer accepts a push on the cycle of a last-chunk transfer.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        after_edge();
        check_val("t3_count", 32'(count), 32'd4);
        check_val("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 2 * DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Host stall mid-entry.
        cyc(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        after_edge();
        held = out_data;
        check_val("t4_chunk1", 32'(held), 32'hBE);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            after_edge();
            check_val("t4_stable", 32'(out_data), 32'hBE);
        end
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        after_edge();
        check_val("t4_drained", 32'(empty), 32'd1);

        // Clear beats a concurrent push; en=0 blocks capture.
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 1'b1, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
        after_edge();
        check_val("t5_empty", 32'(empty), 32'd1);
        check_val("t5_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        after_edge();
        check_val("t5_en_off", 32'(count), 32'd0);

        // Pointer wrap-around, then reset mid-drain.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b1, 16'hC0DE, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'hF00D, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        after_edge();
        check_val("t6_rst_count", 32'(count), 32'd0);
        check_val("t6_rst_valid", 32'(out_valid), 32'd0);
        check_val("t6_rst_last", 32'(out_last), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(199) != 0), ($urandom_range(7) != 0), ($urandom_range(2) == 0),
                16'($urandom), ($urandom_range(49) == 0), ($urandom_range(1) == 0));
        end
        @(negedge clk);
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
